// File: rtl/sync_multi_filt_pkg.sv
// Shared constants and helpers for the multi-channel synchroniser/filter.
// Holds the minimum legal chain depth and the filter counter width calculation.
package sync_multi_filt_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    function automatic int sync_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // The counter never needs to be narrower than one bit, even with filtering off.
    function automatic int sync_cnt_width(input int cycles);
        int w;
        w = sync_clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_multi_filt_chan.sv
// One channel: synchroniser flop chain, stability counter and registered dout/rise/fall.
// The counter holds the run length of the synced level differing from dout; no partial credit.
module sync_multi_filt_chan
    import sync_multi_filt_pkg::*;
#(
    parameter int   STAGES        = 3,
    parameter int   FILTER_CYCLES = 1,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W  = sync_cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             sync_s;

    assign sync_s = sync_q[STAGES-1];

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync_s != dout_q) begin
            if (cnt_q == CNT_TC) begin
                dout_d = sync_s;
                rise_d = sync_s;
                fall_d = ~sync_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_BIT}};
            cnt_q  <= '0;
            dout_q <= RESET_BIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sync_multi_filt.sv
// Multi-channel synchroniser with optional glitch filter and edge pulses.
// Top level: parameter checks, per-channel reset value slicing and the any_change reduction.
module sync_multi_filt
    import sync_multi_filt_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
    parameter int               FILTER_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    generate
        if (STAGES < SYNC_MIN_STAGES || FILTER_CYCLES < 1) begin : g_bad_params
            $error("sync_multi_filt: STAGES must be >= 2 and FILTER_CYCLES >= 1");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_multi_filt_chan #(
            .STAGES        (STAGES),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_BIT     (RESET_VALUE[i])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .din_i  (din[i]),
            .dout_o (dout[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

    // Pulses are already registered, so this adds no latency.
    assign any_change = |(rise | fall);

endmodule

// File: tb/tb_sync_multi_filt.sv
// Bench for sync_multi_filt: three instances (filter 1/4/8) sharing din and rst_n,
// directed latency/glitch/reset scenarios plus randomized traffic against a din-history model.
module tb_sync_multi_filt;

    localparam int         W   = 4;
    localparam int         ST  = 3;
    localparam logic [3:0] RV  = 4'b1010;
    localparam int         FCS [3] = '{1, 4, 8};

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din   = RV;

    logic [3:0] dd [3];
    logic [3:0] rr [3];
    logic [3:0] ff [3];
    logic       ac [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_multi_filt #(.WIDTH(W), .STAGES(ST), .RESET_VALUE(RV), .FILTER_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .dout(dd[0]), .rise(rr[0]), .fall(ff[0]), .any_change(ac[0]));

    sync_multi_filt #(.WIDTH(W), .STAGES(ST), .RESET_VALUE(RV), .FILTER_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .dout(dd[1]), .rise(rr[1]), .fall(ff[1]), .any_change(ac[1]));

    sync_multi_filt #(.WIDTH(W), .STAGES(ST), .RESET_VALUE(RV), .FILTER_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .din(din),
        .dout(dd[2]), .rise(rr[2]), .fall(ff[2]), .any_change(ac[2]));

    // Reference: hist[k] is din as sampled k+1 edges ago. The synced level seen at an
    // edge is din from STAGES edges earlier; dout flips once the last FILTER_CYCLES
    // synced samples all disagree with it.
    logic [3:0] hist [16];
    logic [3:0] md [3];
    logic [3:0] mr [3];
    logic [3:0] mf [3];
    logic [3:0] flip;
    logic       all_diff;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) hist[i] = RV;
            for (int c = 0; c < 3; c++) begin
                md[c] = RV;
                mr[c] = '0;
                mf[c] = '0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                flip = '0;
                for (int ch = 0; ch < W; ch++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < FCS[c]; j++) begin
                        if (hist[ST-1+j][ch] == md[c][ch]) all_diff = 1'b0;
                    end
                    flip[ch] = all_diff;
                end
                mr[c] = flip & ~md[c];
                mf[c] = flip & md[c];
                md[c] = md[c] ^ flip;
            end
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = din;
        end
    end

    task automatic settle(input logic [3:0] v);
        @(posedge clk);
        #2 din = v;
        repeat (16) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2 din = 4'($urandom);
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dd[c] !== RV || rr[c] !== 4'b0 || ff[c] !== 4'b0 || ac[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold inst=%0d dout=%b rise=%b fall=%b any=%b expected dout=%b pulses=0",
                             c, dd[c], rr[c], ff[c], ac[c], RV);
                end
            end
        end
        @(posedge clk);
        #2 din = RV;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dd[c] !== RV || rr[c] !== 4'b0 || ff[c] !== 4'b0 || ac[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_release inst=%0d cyc=%0d dout=%b rise=%b fall=%b any=%b expected dout=%b pulses=0",
                             c, k, dd[c], rr[c], ff[c], ac[c], RV);
                end
            end
        end
    endtask

    task automatic test_latency_nofilter();
        logic [3:0] ed, er;
        settle(4'b0000);
        @(posedge clk);
        #2 din = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            ed = (k >= 4) ? 4'b0001 : 4'b0000;
            er = (k == 4) ? 4'b0001 : 4'b0000;
            checks++;
            if (dd[0] !== ed || rr[0] !== er || ff[0] !== 4'b0) begin
                errors++;
                $display("FAIL latency_f1 edge=%0d dout=%b rise=%b fall=%b expected dout=%b rise=%b fall=0000",
                         k, dd[0], rr[0], ff[0], ed, er);
            end
        end
    endtask

    task automatic test_glitch_reject();
        logic [3:0] ed, er;
        settle(4'b0000);
        @(posedge clk);
        #2 din = 4'b0010;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            if (k == 3) #2 din = 4'b0000;
            @(negedge clk);
            checks++;
            if (dd[1] !== 4'b0000 || rr[1] !== 4'b0 || ff[1] !== 4'b0) begin
                errors++;
                $display("FAIL glitch_f4 edge=%0d dout=%b rise=%b fall=%b expected dout=0000 no pulses",
                         k, dd[1], rr[1], ff[1]);
            end
        end
        @(posedge clk);
        #2 din = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            ed = (k >= 7) ? 4'b0010 : 4'b0000;
            er = (k == 7) ? 4'b0010 : 4'b0000;
            checks++;
            if (dd[1] !== ed || rr[1] !== er || ff[1] !== 4'b0) begin
                errors++;
                $display("FAIL hold_f4 edge=%0d dout=%b rise=%b fall=%b expected dout=%b rise=%b",
                         k, dd[1], rr[1], ff[1], ed, er);
            end
        end
    endtask

    task automatic test_counter_restart();
        logic [3:0] ed, ef;
        settle(4'b0100);
        @(posedge clk);
        #2 din = 4'b0000;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            if (k == 2) #2 din = 4'b0100;
            if (k == 3) #2 din = 4'b0000;
            @(negedge clk);
            ed = (k >= 10) ? 4'b0000 : 4'b0100;
            ef = (k == 10) ? 4'b0100 : 4'b0000;
            checks++;
            if (dd[1] !== ed || ff[1] !== ef || rr[1] !== 4'b0) begin
                errors++;
                $display("FAIL restart_f4 edge=%0d dout=%b fall=%b rise=%b expected dout=%b fall=%b",
                         k, dd[1], ff[1], rr[1], ed, ef);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ed, er, ef;
        settle(4'b1000);
        @(posedge clk);
        #2 din = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            ed = (k >= 4) ? 4'b0001 : 4'b1000;
            er = (k == 4) ? 4'b0001 : 4'b0000;
            ef = (k == 4) ? 4'b1000 : 4'b0000;
            checks++;
            if (dd[0] !== ed || rr[0] !== er || ff[0] !== ef || ac[0] !== (k == 4)) begin
                errors++;
                $display("FAIL simult_f1 edge=%0d dout=%b rise=%b fall=%b any=%b expected %b %b %b %0d",
                         k, dd[0], rr[0], ff[0], ac[0], ed, er, ef, (k == 4));
            end
            checks++;
            if (ac[1] !== (k == 7)) begin
                errors++;
                $display("FAIL simult_any_f4 edge=%0d any=%b expected %0d", k, ac[1], (k == 7));
            end
        end
    endtask

    task automatic test_reset_midcount();
        logic [3:0] ed, er, ef;
        settle(4'b0000);
        @(posedge clk);
        #2 din = 4'b0100;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dd[2] !== 4'b0000) begin
            errors++;
            $display("FAIL midcount_pre dout=%b expected 0000", dd[2]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dd[2] !== RV || rr[2] !== 4'b0 || ff[2] !== 4'b0) begin
            errors++;
            $display("FAIL midcount_async dout=%b rise=%b fall=%b expected dout=%b no pulses",
                     dd[2], rr[2], ff[2], RV);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            ed = (k >= 11) ? 4'b0100 : RV;
            er = (k == 11) ? 4'b0100 : 4'b0000;
            ef = (k == 11) ? 4'b1010 : 4'b0000;
            checks++;
            if (dd[2] !== ed || rr[2] !== er || ff[2] !== ef) begin
                errors++;
                $display("FAIL midcount_refilter edge=%0d dout=%b rise=%b fall=%b expected %b %b %b",
                         k, dd[2], rr[2], ff[2], ed, er, ef);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 700; i++) begin
            @(posedge clk);
            if (i == 350) #2 rst_n = 1'b0;
            if (i == 354) #2 rst_n = 1'b1;
            if (hold == 0) begin
                #2 din = din ^ 4'($urandom_range(1, 15));
                hold = (i % 200 < 100) ? $urandom_range(1, 5) : $urandom_range(4, 14);
            end else begin
                hold--;
            end
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (dd[c] !== md[c] || rr[c] !== mr[c] || ff[c] !== mf[c] || ac[c] !== (|(mr[c] | mf[c]))) begin
                    errors++;
                    $display("FAIL random inst=%0d cyc=%0d dout=%b rise=%b fall=%b any=%b expected %b %b %b %b",
                             c, i, dd[c], rr[c], ff[c], ac[c], md[c], mr[c], mf[c], |(mr[c] | mf[c]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_nofilter();
        test_glitch_reject();
        test_counter_restart();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
